tilt_motion_ctrl: RTL
=====================

TILT_MOTION_CTRL -- requirements
Module: tilt_motion_ctrl

Interface
REQ-001 Parameter SCREEN_W, 640, visible width in pixels.
REQ-002 Parameter SCREEN_H, 480, visible height in pixels.
REQ-003 Parameter OBJ_SIZE, 16, square object edge in pixels.
REQ-004 Parameter DEADZONE, 2, tilt magnitude at or below which no motion occurs.
REQ-005 Parameter STABLE_CYC, 4, consecutive equal synchronized samples required to accept acl_data.
REQ-006 CLK100MHZ  in  1  sole clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 acl_data  in  15  packed tilt from the SPI accelerometer stage (4 MHz domain): X=[14:10], Y=[9:5], Z=[4:0], each 5-bit two's complement.
REQ-009 vsync  in  1  active-low vertical sync from the VGA stage, same clock domain.
REQ-010 pos_x  out  10  object top-left column, consumed by the VGA stage.
REQ-011 pos_y  out  10  object top-left row.
REQ-012 pos_upd  out  1  one-cycle pulse when pos_x/pos_y change register.
REQ-013 moving  out  1  high if either axis step was nonzero at the last update.
REQ-014 at_edge  out  4  {left,right,top,bottom} clamp flags from the last update.

Function
REQ-015 acl_data SHALL pass a 2-flop synchronizer; the synchronized word SHALL be latched into the tilt register only after it is equal for STABLE_CYC consecutive cycles; Z is latched but unused.
REQ-016 A frame event SHALL be the cycle in which vsync is sampled 0 and was 1 the previous cycle.
REQ-017 FSM states: IDLE, FILTER, MOVE_X, MOVE_Y; IDLE->FILTER on frame event; FILTER->MOVE_X->MOVE_Y->IDLE unconditionally, one cycle each.
REQ-018 Frame events outside IDLE SHALL be ignored; tilt register updates during FILTER..MOVE_Y SHALL NOT affect the step captured in FILTER.
REQ-019 In FILTER, each axis SHALL produce a filtered tilt t (5-bit signed, -16..15) and a step = 0 if |t| <= DEADZONE, else sign(t)*(|t|-DEADZONE), range -14..+14.
REQ-020 Positive X step SHALL increase pos_x; positive Y step SHALL increase pos_y.
REQ-021 New positions SHALL be computed in 11-bit signed arithmetic and saturated to [0, SCREEN_W-OBJ_SIZE] for X and [0, SCREEN_H-OBJ_SIZE] for Y.
REQ-022 pos_x, pos_y, moving, and at_edge SHALL register together on the MOVE_Y->IDLE edge, with pos_upd high for exactly the following cycle; the latency is 4 rising edges, counting the edge that first samples vsync low.
REQ-023 An at_edge bit SHALL be set when the saturated result equals its bound, even with step 0.

Reset
REQ-024 Reset SHALL force: FSM to IDLE; pos_x=(SCREEN_W-OBJ_SIZE)/2=312; pos_y=(SCREEN_H-OBJ_SIZE)/2=232; pos_upd=0; moving=0; at_edge=0; tilt register, synchronizer, stability counter, and filter history to 0.
REQ-025 Reset asserted mid-sequence SHALL abort the update with no pos_upd pulse.

Configuration
REQ-026 With TILT_FILTER_EN defined, each axis SHALL hold a 4-entry history: in FILTER, the current tilt is pushed, the oldest is dropped, and t = (7-bit signed sum) >>> 2 (floor).
REQ-027 Without TILT_FILTER_EN, t SHALL be the current latched tilt and no history registers SHALL exist.

Structure
REQ-028 Package tilt_pkg SHALL hold the FSM state enum, default geometry constants, centre constants, and DEADZONE/STABLE_CYC defaults.
REQ-029 Sub-module tilt_axis_filter (history, average, deadzone, step) SHALL be instantiated once per axis (X, Y).

Verification
REQ-030 Filter off, X=+10, Y=0 held stable, one vsync fall -> pos_x 312->320, pos_y 232, pos_upd single pulse 4 edges after fall, moving=1.
REQ-031 Filter off, pos_x=620, pos_y=5, X=+15, Y=-16, one frame -> pos_x=624, pos_y=0, at_edge=4'b0110.
REQ-032 Filter off, X=+2, Y=-2 -> positions unchanged, moving=0, pos_upd still pulses.
REQ-033 acl_data toggles between 15'h0000 and X=+10 every 2 cycles across 3 frames -> tilt never latched, pos_x stays 312.
REQ-034 TILT_FILTER_EN, X=+8 from reset, 4 frames -> pos_x 312, 314, 318, 324.
REQ-035 Reset asserted in MOVE_X -> no pos_upd pulse, positions return to 312/232, FSM IDLE.

Source files
------------

// File: rtl/tilt_pkg.sv
// Shared types, default geometry and the saturating position helper for the tilt motion controller.
package tilt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILTER,
        ST_MOVE_X,
        ST_MOVE_Y
    } state_e;

    localparam int SCREEN_W_DEF   = 640;
    localparam int SCREEN_H_DEF   = 480;
    localparam int OBJ_SIZE_DEF   = 16;
    localparam int DEADZONE_DEF   = 2;
    localparam int STABLE_CYC_DEF = 4;

    localparam int CENTRE_X_DEF = (SCREEN_W_DEF - OBJ_SIZE_DEF) / 2;
    localparam int CENTRE_Y_DEF = (SCREEN_H_DEF - OBJ_SIZE_DEF) / 2;

    function automatic logic [9:0] centre(input int scr, input int obj);
        return 10'((scr - obj) / 2);
    endfunction

    // Add a signed step in 11-bit signed arithmetic, clamp to [0, hi].
    function automatic logic [9:0] sat_add(input logic [9:0] pos,
                                           input logic signed [5:0] step,
                                           input logic [9:0] hi);
        logic signed [10:0] s;
        s = $signed({1'b0, pos}) + $signed({{5{step[5]}}, step});
        if (s < 0) begin
            return '0;
        end else if (s > $signed({1'b0, hi})) begin
            return hi;
        end
        return s[9:0];
    endfunction

endpackage

// File: rtl/tilt_motion_ctrl_if.sv
// Tilt input / object position bundle between the sensor + VGA stages and the motion controller.
interface tilt_motion_ctrl_if;
    logic [14:0] acl_data;
    logic        vsync;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        pos_upd;
    logic        moving;
    logic [3:0]  at_edge;

    modport master (
        output acl_data, vsync,
        input  pos_x, pos_y, pos_upd, moving, at_edge
    );

    modport slave (
        input  acl_data, vsync,
        output pos_x, pos_y, pos_upd, moving, at_edge
    );
endinterface

// File: rtl/tilt_axis_filter.sv
// One tilt axis: optional 4-deep moving average (TILT_FILTER_EN), deadzone, signed step.
// Filter state advances only on push_i; step_o is valid from the cycle after push_i.
module tilt_axis_filter
    import tilt_pkg::*;
#(
    parameter int DEADZONE = DEADZONE_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic signed [4:0] tilt_i,
    output logic signed [5:0] step_o
);

    localparam logic signed [5:0] DZ = 6'(DEADZONE);

    logic signed [4:0] t;
    logic signed [5:0] t_ext;
    logic signed [5:0] mag;

`ifdef TILT_FILTER_EN
    logic signed [4:0] hist_q [4];
    logic signed [6:0] sum;

    function automatic logic signed [6:0] sx7(input logic signed [4:0] v);
        return {{2{v[4]}}, v};
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
        end else if (push_i) begin
            hist_q[0] <= tilt_i;
            hist_q[1] <= hist_q[0];
            hist_q[2] <= hist_q[1];
            hist_q[3] <= hist_q[2];
        end
    end

    always_comb begin
        sum = sx7(hist_q[0]) + sx7(hist_q[1]) + sx7(hist_q[2]) + sx7(hist_q[3]);
        t   = 5'(sum >>> 2);
    end
`else
    logic signed [4:0] t_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            t_q <= '0;
        end else if (push_i) begin
            t_q <= tilt_i;
        end
    end

    always_comb t = t_q;
`endif

    always_comb begin
        t_ext  = {t[4], t};
        mag    = t_ext[5] ? -t_ext : t_ext;
        step_o = '0;
        if (mag > DZ) begin
            step_o = t_ext[5] ? (DZ - mag) : (mag - DZ);
        end
    end

endmodule

// File: rtl/tilt_motion_ctrl.sv
// Moves a square object once per frame by accelerometer tilt; outputs update 4 edges after vsync falls.
// Optional history averaging via TILT_FILTER_EN; no backpressure, pos_upd is a one-cycle strobe.
module tilt_motion_ctrl
    import tilt_pkg::*;
#(
    parameter int SCREEN_W   = SCREEN_W_DEF,
    parameter int SCREEN_H   = SCREEN_H_DEF,
    parameter int OBJ_SIZE   = OBJ_SIZE_DEF,
    parameter int DEADZONE   = DEADZONE_DEF,
    parameter int STABLE_CYC = STABLE_CYC_DEF
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    tilt_motion_ctrl_if.slave bus
);

    localparam logic [9:0] MAX_X = 10'(SCREEN_W - OBJ_SIZE);
    localparam logic [9:0] MAX_Y = 10'(SCREEN_H - OBJ_SIZE);
    localparam logic [9:0] RST_X = centre(SCREEN_W, OBJ_SIZE);
    localparam logic [9:0] RST_Y = centre(SCREEN_H, OBJ_SIZE);
    localparam logic [7:0] STAB  = 8'(STABLE_CYC);

    logic [14:0] acl_s1_q, acl_s2_q, acl_hold_q, tilt_q;
    logic [7:0]  stab_cnt_q, stab_cnt_d;
    logic        tilt_ld;
    logic        vsync_q;
    logic        frame_evt;
    state_e      state_q, state_d;
    logic        push;

    logic signed [5:0] step_x, step_y;
    logic [9:0]  nx_q, ny;
    logic        mov_x_q;
    logic [9:0]  pos_x_q, pos_y_q;
    logic        pos_upd_q, moving_q;
    logic [3:0]  at_edge_q;
    logic        unused_z;

    assign unused_z = ^tilt_q[4:0];

    // Stability count includes the current sample; a change restarts it at one.
    always_comb begin
        stab_cnt_d = 8'd1;
        if (acl_s2_q == acl_hold_q) begin
            stab_cnt_d = (stab_cnt_q >= STAB) ? STAB : stab_cnt_q + 8'd1;
        end
        tilt_ld = (stab_cnt_d >= STAB);
    end

    assign frame_evt = vsync_q & ~bus.vsync;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE:   if (frame_evt) state_d = ST_FILTER;
            ST_FILTER: begin
                push    = 1'b1;
                state_d = ST_MOVE_X;
            end
            ST_MOVE_X: state_d = ST_MOVE_Y;
            ST_MOVE_Y: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    tilt_axis_filter #(.DEADZONE(DEADZONE)) u_filt_x (
        .clk_i  (CLK100MHZ),
        .rst_i  (reset),
        .push_i (push),
        .tilt_i (tilt_q[14:10]),
        .step_o (step_x)
    );

    tilt_axis_filter #(.DEADZONE(DEADZONE)) u_filt_y (
        .clk_i  (CLK100MHZ),
        .rst_i  (reset),
        .push_i (push),
        .tilt_i (tilt_q[9:5]),
        .step_o (step_y)
    );

    assign ny = sat_add(pos_y_q, step_y, MAX_Y);

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            acl_s1_q   <= '0;
            acl_s2_q   <= '0;
            acl_hold_q <= '0;
            stab_cnt_q <= '0;
            tilt_q     <= '0;
            vsync_q    <= 1'b0;
            state_q    <= ST_IDLE;
            nx_q       <= RST_X;
            mov_x_q    <= 1'b0;
            pos_x_q    <= RST_X;
            pos_y_q    <= RST_Y;
            pos_upd_q  <= 1'b0;
            moving_q   <= 1'b0;
            at_edge_q  <= '0;
        end else begin
            acl_s1_q   <= bus.acl_data;
            acl_s2_q   <= acl_s1_q;
            acl_hold_q <= acl_s2_q;
            stab_cnt_q <= stab_cnt_d;
            if (tilt_ld) tilt_q <= acl_s2_q;
            vsync_q    <= bus.vsync;
            state_q    <= state_d;
            pos_upd_q  <= 1'b0;
            if (state_q == ST_MOVE_X) begin
                nx_q    <= sat_add(pos_x_q, step_x, MAX_X);
                mov_x_q <= (step_x != 0);
            end
            if (state_q == ST_MOVE_Y) begin
                pos_x_q   <= nx_q;
                pos_y_q   <= ny;
                moving_q  <= mov_x_q | (step_y != 0);
                at_edge_q <= {nx_q == 10'd0, nx_q == MAX_X, ny == 10'd0, ny == MAX_Y};
                pos_upd_q <= 1'b1;
            end
        end
    end

    assign bus.pos_x   = pos_x_q;
    assign bus.pos_y   = pos_y_q;
    assign bus.pos_upd = pos_upd_q;
    assign bus.moving  = moving_q;
    assign bus.at_edge = at_edge_q;

endmodule
